// File: rtl/dmem_responder.sv
// Data-memory responder for the single-cycle core.
// Multi-cycle byte-enabled load/store with stall and fault reporting.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs,
    input  logic              load_store,
    input  logic [2:0]        load_ops,
    input  logic [2:0]        store_ops,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              rvalid,
    output logic              stall,
    output logic              misalign
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int LA_W  = IDX_W + 2;
    localparam logic [ADDR_W-3:0] DEPTH_L = (ADDR_W-2)'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE,
        FAULT
    } state_e;

    state_e            state_q, state_d;
    logic [LA_W-1:0]   laddr_q;
    logic [2:0]        lop_q;
    logic [2:0]        sop_q;
    logic              ls_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic [31:0]       mem_q [DEPTH_WORDS];

    logic              bad_op;
    logic              bad_align;
    logic              bad_range;
    logic              fault;
    logic              accept;
    logic [IDX_W-1:0]  widx;
    logic [31:0]       rd_word;
    logic [31:0]       rd_sh;
    logic [31:0]       rd_ext;
    logic [3:0]        be;
    logic [31:0]       wlane;

    assign bad_range = addr[ADDR_W-1:2] >= DEPTH_L;
    assign fault     = bad_op | bad_align | bad_range;
    assign widx      = laddr_q[LA_W-1:2];

    // Classify the presented request: illegal op or misaligned access.
    always_comb begin
        bad_op    = 1'b0;
        bad_align = 1'b0;
        if (load_store) begin
            case (load_ops)
                3'b000, 3'b001: bad_align = 1'b0;
                3'b010, 3'b011: bad_align = addr[0];
                3'b100:         bad_align = |addr[1:0];
                default:        bad_op    = 1'b1;
            endcase
        end else begin
            case (store_ops)
                3'b000:  bad_align = 1'b0;
                3'b001:  bad_align = addr[0];
                3'b010:  bad_align = |addr[1:0];
                default: bad_op    = 1'b1;
            endcase
        end
    end

    // Next-state and stall decode.
    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!cs) begin
                    stall   = !fault;
                    accept  = !fault;
                    state_d = fault ? FAULT : BUSY;
                end
            end
            BUSY: begin
                stall   = 1'b1;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            FAULT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign rvalid   = (state_q == DONE) && ls_q;
    assign misalign = (state_q == FAULT);
    assign rdata    = rdata_q;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Capture the request so later input changes are ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            laddr_q <= '0;
            lop_q   <= '0;
            sop_q   <= '0;
            ls_q    <= 1'b0;
            wdata_q <= '0;
        end else if (accept) begin
            laddr_q <= addr[LA_W-1:0];
            lop_q   <= load_ops;
            sop_q   <= store_ops;
            ls_q    <= load_store;
            wdata_q <= wdata;
        end
    end

    // Read path: select lane then extend.
    always_comb begin
        rd_word = mem_q[widx];
        rd_sh   = rd_word >> {laddr_q[1:0], 3'b000};
        case (lop_q)
            3'b000:  rd_ext = {{24{rd_sh[7]}}, rd_sh[7:0]};
            3'b001:  rd_ext = {24'h0, rd_sh[7:0]};
            3'b010:  rd_ext = {{16{rd_sh[15]}}, rd_sh[15:0]};
            3'b011:  rd_ext = {16'h0, rd_sh[15:0]};
            default: rd_ext = rd_sh;
        endcase
    end

    // Load result register, held until the next load completes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                       rdata_q <= '0;
        else if (state_q == BUSY && ls_q) rdata_q <= rd_ext;
    end

    // Byte-lane enables and replicated store data.
    always_comb begin
        case (sop_q)
            3'b000: begin
                be    = 4'b0001 << laddr_q[1:0];
                wlane = {4{wdata_q[7:0]}};
            end
            3'b001: begin
                be    = laddr_q[1] ? 4'b1100 : 4'b0011;
                wlane = {2{wdata_q[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wlane = wdata_q;
            end
        endcase
    end

    // Array write happens only on the edge leaving BUSY.
    always_ff @(posedge clk) begin
        if (state_q == BUSY && !ls_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem_q[widx][i*8 +: 8] <= wlane[i*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vectors plus random traffic
// checked against a byte-addressed reference model.
module tb_dmem_responder;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs;
    logic        load_store;
    logic [2:0]  load_ops;
    logic [2:0]  store_ops;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic        stall;
    logic        misalign;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0]  mref [int unsigned];
    logic [31:0] last_rd = 32'h0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .ADDR_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .cs         (cs),
        .load_store (load_store),
        .load_ops   (load_ops),
        .store_ops  (store_ops),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .rvalid     (rvalid),
        .stall      (stall),
        .misalign   (misalign)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit m_fault(input bit ls, input logic [2:0] lop,
                                   input logic [2:0] sop,
                                   input logic [31:0] a);
        if ((a / 4) >= DEPTH) return 1'b1;
        if (ls) begin
            if (lop > 4) return 1'b1;
            if ((lop == 2 || lop == 3) && (a % 2) != 0) return 1'b1;
            if (lop == 4 && (a % 4) != 0) return 1'b1;
        end else begin
            if (sop > 2) return 1'b1;
            if (sop == 1 && (a % 2) != 0) return 1'b1;
            if (sop == 2 && (a % 4) != 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] lop,
                                           input logic [31:0] a);
        int n;
        logic [63:0] v;
        n = (lop == 4) ? 4 : ((lop >= 2) ? 2 : 1);
        v = 64'h0;
        for (int k = 0; k < n; k++)
            v = v | (64'(mref[a + k]) << (8 * k));
        if ((lop == 0 || lop == 2) && v[8*n-1])
            v = v | ~((64'h1 << (8 * n)) - 64'h1);
        return v[31:0];
    endfunction

    task automatic m_store(input logic [2:0] sop, input logic [31:0] a,
                           input logic [31:0] wd);
        int n;
        n = 1 << sop;
        for (int k = 0; k < n; k++) mref[a + k] = wd[8*k +: 8];
    endtask

    // One request from IDLE; returns at posedge+1 with the DUT in IDLE.
    task automatic req(input bit ls, input logic [2:0] lop,
                       input logic [2:0] sop, input logic [31:0] a,
                       input logic [31:0] wd, input string tag);
        bit f;
        logic [31:0] exp;
        f   = m_fault(ls, lop, sop, a);
        exp = (!f && ls) ? m_load(lop, a) : 32'h0;
        cs = 1'b0;
        load_store = ls;
        load_ops = lop;
        store_ops = sop;
        addr = a;
        wdata = wd;
        @(negedge clk);
        chk({tag, "_stall_accept"}, 32'(stall), 32'(!f));
        chk({tag, "_misalign_idle"}, 32'(misalign), 32'h0);
        chk({tag, "_rvalid_idle"}, 32'(rvalid), 32'h0);
        @(posedge clk);
        #1;
        cs = 1'b1;
        addr = $urandom;
        wdata = $urandom;
        load_ops = 3'($urandom);
        store_ops = 3'($urandom);
        load_store = 1'($urandom);
        @(negedge clk);
        if (f) begin
            chk({tag, "_misalign"}, 32'(misalign), 32'h1);
            chk({tag, "_stall_fault"}, 32'(stall), 32'h0);
            chk({tag, "_rvalid_fault"}, 32'(rvalid), 32'h0);
            @(posedge clk);
            #1;
        end else begin
            chk({tag, "_stall_busy"}, 32'(stall), 32'h1);
            chk({tag, "_rvalid_busy"}, 32'(rvalid), 32'h0);
            @(posedge clk);
            #1;
            @(negedge clk);
            chk({tag, "_stall_done"}, 32'(stall), 32'h0);
            chk({tag, "_rvalid_done"}, 32'(rvalid), 32'(ls));
            chk({tag, "_misalign_done"}, 32'(misalign), 32'h0);
            if (ls) last_rd = exp;
            else    m_store(sop, a, wd);
            chk({tag, "_rdata"}, rdata, last_rd);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [31:0] a;
        reset = 1'b0;
        cs = 1'b1;
        load_store = 1'b0;
        load_ops = 3'b0;
        store_ops = 3'b0;
        addr = 32'h0;
        wdata = 32'h0;
        #12;
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_rvalid", 32'(rvalid), 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_misalign", 32'(misalign), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int w = 0; w < 16; w++)
            req(1'b0, 3'd0, 3'd2, 32'(w * 4), $urandom, "init_sw");

        req(1'b0, 3'd0, 3'd2, 32'h10, 32'hDEADBEEF, "sw_10");
        req(1'b1, 3'd0, 3'd0, 32'h13, 32'h0, "lb_13");
        chk("lb_13_const", rdata, 32'hFFFFFFDE);
        req(1'b1, 3'd1, 3'd0, 32'h13, 32'h0, "lbu_13");
        chk("lbu_13_const", rdata, 32'h000000DE);
        req(1'b1, 3'd2, 3'd0, 32'h12, 32'h0, "lh_12");
        chk("lh_12_const", rdata, 32'hFFFFDEAD);
        req(1'b1, 3'd3, 3'd0, 32'h10, 32'h0, "lhu_10");
        chk("lhu_10_const", rdata, 32'h0000BEEF);
        req(1'b0, 3'd0, 3'd0, 32'h11, 32'h1234567A, "sb_11");
        chk("sb_rdata_hold", rdata, 32'h0000BEEF);
        req(1'b1, 3'd4, 3'd0, 32'h10, 32'h0, "lw_10a");
        chk("lw_10a_const", rdata, 32'hDEAD7AEF);
        req(1'b0, 3'd0, 3'd1, 32'h12, 32'h00008001, "sh_12");
        req(1'b1, 3'd4, 3'd0, 32'h10, 32'h0, "lw_10b");
        chk("lw_10b_const", rdata, 32'h80017AEF);

        req(1'b1, 3'd4, 3'd0, 32'h12, 32'h0, "lw_12_mis");
        req(1'b0, 3'd0, 3'd1, 32'h11, 32'hFFFFFFFF, "sh_11_mis");
        req(1'b1, 3'd5, 3'd0, 32'h10, 32'h0, "lop5_ill");
        req(1'b0, 3'd0, 3'd3, 32'h10, 32'hFFFFFFFF, "sop3_ill");
        req(1'b1, 3'd4, 3'd0, 32'h10, 32'h0, "lw_10c");
        chk("lw_10c_const", rdata, 32'h80017AEF);

        req(1'b0, 3'd0, 3'd2, 32'h1000, 32'hCAFEF00D, "sw_range");
        req(1'b0, 3'd0, 3'd0, 32'h1003, 32'hCAFEF00D, "sb_range");
        req(1'b0, 3'd0, 3'd2, 32'hFFC, 32'hA5A55A5A, "sw_last");
        req(1'b1, 3'd4, 3'd0, 32'hFFC, 32'h0, "lw_last");
        chk("lw_last_const", rdata, 32'hA5A55A5A);

        cs = 1'b0;
        load_store = 1'b0;
        store_ops = 3'd2;
        addr = 32'h20;
        wdata = 32'h11111111;
        @(posedge clk);
        #1;
        cs = 1'b1;
        reset = 1'b0;
        #1;
        chk("rstbusy_stall", 32'(stall), 32'h0);
        chk("rstbusy_rvalid", 32'(rvalid), 32'h0);
        chk("rstbusy_misalign", 32'(misalign), 32'h0);
        chk("rstbusy_rdata", rdata, 32'h0);
        last_rd = 32'h0;
        @(negedge clk);
        chk("rstbusy_rvalid_hold", 32'(rvalid), 32'h0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        req(1'b1, 3'd4, 3'd0, 32'h20, 32'h0, "lw_20_after_rst");

        for (int t = 0; t < 200; t++) begin
            if ($urandom_range(0, 9) == 0)
                a = $urandom | 32'h1000_0000;
            else
                a = 32'($urandom_range(0, 63));
            req(1'($urandom), 3'($urandom_range(0, 5)),
                3'($urandom_range(0, 3)), a, $urandom, "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
